// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        MISALIGNED  = 2'd1,
        BUS_TIMEOUT = 2'd2
    } err_cause_t;

endpackage

// File: rtl/lsu_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_unit_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Lane steering for stores, legality/alignment check, and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_illegal,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_misaligned;
    logic        w_bad_f3;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        unique case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Stores have no unsigned variants, so funct3[2] is illegal for them.
    assign w_bad_f3 = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) || (i_we && i_funct3[2]);
    assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0])
                       || ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    assign o_illegal = w_bad_f3 || w_misaligned;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load = i_rdata;
        case (i_funct3)
            LB:      o_load = {{24{w_byte[7]}}, w_byte};
            LBU:     o_load = {24'h0, w_byte};
            LH:      o_load = {{16{w_half[15]}}, w_half};
            LHU:     o_load = {16'h0, w_half};
            default: o_load = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: issues one word-aligned bus transaction per operation and
// returns extended load data or an error to writeback.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [1:0]        err_cause_o,
    lsu_unit_if.master        mem_if
);

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    lsu_state_t        r_state, w_state_d;
    err_cause_t        r_cause, w_cause;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_inc;
    logic              w_timeout;
    logic              w_accept;
    logic              w_finish;
    logic              w_idle;
    logic              w_al_we;
    logic [2:0]        w_al_f3;
    logic [1:0]        w_al_lo;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_illegal;
    logic [31:0]       w_load;

    assign w_idle = (r_state == IDLE);

    // In IDLE the aligner looks at the incoming operation; otherwise at the latched one.
    assign w_al_we = w_idle ? we_i : r_we;
    assign w_al_f3 = w_idle ? funct3_i : r_funct3;
    assign w_al_lo = w_idle ? addr_i[1:0] : r_addr_lo;

    lsu_align u_align (
        .i_we      (w_al_we),
        .i_funct3  (w_al_f3),
        .i_addr_lo (w_al_lo),
        .i_wdata   (wdata_i),
        .i_rdata   (mem_if.mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_illegal (w_illegal),
        .o_load    (w_load)
    );

    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc >= TMO);

    always_comb begin
        w_state_d = r_state;
        w_cause   = NONE;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    if (w_illegal) begin
                        w_state_d = RESP;
                        w_cause   = MISALIGNED;
                    end else begin
                        w_state_d = REQ;
                        w_accept  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_if.mem_gnt && mem_if.mem_rvalid) begin
                    w_state_d = RESP;
                end else if (w_timeout) begin
                    w_state_d = RESP;
                    w_cause   = BUS_TIMEOUT;
                end else if (mem_if.mem_gnt) begin
                    w_state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_if.mem_rvalid) begin
                    w_state_d = RESP;
                end else if (w_timeout) begin
                    w_state_d = RESP;
                    w_cause   = BUS_TIMEOUT;
                end
            end
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    assign w_finish = (w_state_d == RESP) && (r_state != RESP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cause   <= NONE;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_addr    <= '0;
            r_be      <= 4'b0000;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_cnt     <= 8'h00;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_we      <= we_i;
                r_funct3  <= funct3_i;
                r_addr_lo <= addr_i[1:0];
                r_addr    <= {addr_i[ADDR_W-1:2], 2'b00};
                r_be      <= w_be;
                r_wdata   <= w_wdata;
                r_cnt     <= 8'h00;
            end else if ((r_state == REQ) || (r_state == WAIT)) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_finish) begin
                r_cause <= w_cause;
                r_rdata <= ((w_cause == NONE) && !r_we) ? w_load : 32'h0;
            end
        end
    end

    assign busy_o      = !w_idle;
    assign done_o      = (r_state == RESP);
    assign rdata_o     = r_rdata;
    assign err_o       = (r_cause != NONE);
    assign err_cause_o = r_cause;

    assign mem_if.mem_req   = (r_state == REQ);
    assign mem_if.mem_we    = r_we;
    assign mem_if.mem_addr  = r_addr;
    assign mem_if.mem_be    = r_be;
    assign mem_if.mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: expected completions are queued at issue and
// popped when done_o fires; a small memory responder is driven per operation.
module tb_lsu_unit;

    localparam int TMO = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [1:0]  err_cause_o;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb_q[$];

    lsu_unit_if #(.ADDR_W(32)) mem_if ();

    lsu_unit #(
        .TIMEOUT_CYC (TMO),
        .ADDR_W      (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .we_i        (we_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .err_cause_o (err_cause_o),
        .mem_if      (mem_if)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lo);
        if (f3[1:0] == 2'b00) return 4'b0001 << lo;
        if (f3[1:0] == 2'b01) return lo[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (f3[1:0] == 2'b01) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] word);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = word >> (8 * int'(lo));
        b  = sh[7:0];
        h  = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic m_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lo);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (f3[1:0] == 2'b01 && lo[0]) return 1'b1;
        if (f3[1:0] == 2'b10 && lo != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // gnt_dly: REQ cycle index (0-based) at which gnt is given; negative = never.
    // same: return rvalid together with gnt. exp_lat: cycles from valid to done, 0 = skip.
    task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] word, input int gnt_dly, input bit same,
                         input int exp_lat);
        exp_t e;
        exp_t got;
        logic bad;
        int   exp_req;
        int   req_cyc = 0;
        int   bus_bad = 0;
        int   busy_bad = 0;
        int   lat = 0;
        bit   seen = 0;
        bit   rv_pend = 0;
        bad     = m_illegal(we, f3, addr[1:0]);
        e.cause = bad ? 2'd1 : ((gnt_dly < 0) ? 2'd2 : 2'd0);
        e.err   = (e.cause != 2'd0);
        e.rdata = (e.cause == 2'd0 && !we) ? m_load(f3, addr[1:0], word) : 32'h0;
        sb_q.push_back(e);
        exp_req = bad ? 0 : ((gnt_dly < 0) ? TMO : gnt_dly + 1);

        @(negedge clk);
        valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        @(negedge clk);
        valid_i = 1'b0; addr_i = ~addr; wdata_i = ~wd;
        for (int k = 1; k <= 40; k++) begin
            lat = k;
            mem_if.mem_gnt    = 1'b0;
            mem_if.mem_rvalid = 1'b0;
            mem_if.mem_rdata  = 32'h5A5A_5A5A;
            if (rv_pend) begin
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = word;
                rv_pend = 0;
            end
            if (done_o) begin
                seen = 1;
                break;
            end
            if (!busy_o) busy_bad++;
            if (mem_if.mem_req) begin
                if (mem_if.mem_addr !== {addr[31:2], 2'b00} || mem_if.mem_we !== we
                    || mem_if.mem_be !== m_be(f3, addr[1:0])
                    || mem_if.mem_wdata !== m_wdata(f3, wd)) bus_bad++;
                if (req_cyc == gnt_dly) begin
                    mem_if.mem_gnt = 1'b1;
                    if (same) begin
                        mem_if.mem_rvalid = 1'b1;
                        mem_if.mem_rdata  = word;
                    end else begin
                        rv_pend = 1;
                    end
                end
                req_cyc++;
            end
            @(negedge clk);
        end

        n_checks++;
        if (!seen) begin
            $display("FAIL %s done_wait: no done_o within 40 cycles", name);
            void'(sb_q.pop_front());
        end else begin
            n_pass++;
            got = sb_q.pop_front();
            n_checks++;
            if (rdata_o !== got.rdata)
                $display("FAIL %s rdata: got %h want %h", name, rdata_o, got.rdata);
            else n_pass++;
            n_checks++;
            if (err_o !== got.err || err_cause_o !== got.cause)
                $display("FAIL %s err: got %b/%0d want %b/%0d", name, err_o, err_cause_o,
                         got.err, got.cause);
            else n_pass++;
            n_checks++;
            if (mem_if.mem_req !== 1'b0)
                $display("FAIL %s req_at_done: got %b want 0", name, mem_if.mem_req);
            else n_pass++;
        end
        n_checks++;
        if (req_cyc != exp_req)
            $display("FAIL %s req_cycles: got %0d want %0d", name, req_cyc, exp_req);
        else n_pass++;
        n_checks++;
        if (bus_bad != 0 || busy_bad != 0)
            $display("FAIL %s bus_stable: bad_bus=%0d bad_busy=%0d want 0/0", name, bus_bad,
                     busy_bad);
        else n_pass++;
        if (exp_lat > 0) begin
            n_checks++;
            if (lat != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b0 || rdata_o !== e.rdata)
            $display("FAIL %s after_done: done=%b rdata=%h want 0/%h", name, done_o, rdata_o,
                     e.rdata);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        n_checks++;
        if ({busy_o, done_o, err_o, err_cause_o, rdata_o} !== 37'h0)
            $display("FAIL reset_status: got busy=%b done=%b err=%b cause=%0d rdata=%h want 0",
                     busy_o, done_o, err_o, err_cause_o, rdata_o);
        else n_pass++;
        n_checks++;
        if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata}
            !== 70'h0)
            $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h want 0",
                     mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be,
                     mem_if.mem_wdata);
        else n_pass++;
    endtask

    task automatic test_store_word;
        do_op("sw", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0, 3);
    endtask

    task automatic test_load_byte;
        do_op("lb", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 3);
        do_op("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 3);
    endtask

    task automatic test_load_half;
        do_op("lh", 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 0, 3);
        do_op("lhu_lo", 1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h8001_F00D, 1, 0, 4);
        do_op("lh_mis", 1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h8001_7FFF, 0, 0, 1);
        do_op("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 0, 1);
    endtask

    task automatic test_store_byte_delayed;
        do_op("sb_dly", 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0, 5, 0, 8);
        do_op("sh_hi", 1'b1, 3'b001, 32'h0000_0206, 32'h1234_C0DE, 32'h0, 2, 0, 5);
    endtask

    task automatic test_timeout;
        do_op("timeout", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, -1, 0, TMO + 1);
    endtask

    task automatic test_back_to_back;
        do_op("b2b_lhu", 1'b0, 3'b101, 32'h0000_0302, 32'h0, 32'h1234_ABCD, 0, 0, 3);
        do_op("b2b_lw", 1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'hCAFE_F00D, 0, 1, 2);
    endtask

    task automatic test_illegal;
        do_op("f3_011", 1'b0, 3'b011, 32'h0000_0500, 32'h0, 32'h0, 0, 0, 1);
        do_op("st_f3_100", 1'b1, 3'b100, 32'h0000_0500, 32'h55, 32'h0, 0, 0, 1);
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        @(negedge clk);
        valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0400;
        @(negedge clk);
        valid_i = 1'b0;
        mem_if.mem_gnt = mem_if.mem_req;
        @(negedge clk);
        mem_if.mem_gnt = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || mem_if.mem_req !== 1'b0)
            $display("FAIL rst_mid_idle: got busy=%b req=%b want 0/0", busy_o, mem_if.mem_req);
        else n_pass++;
        @(negedge clk);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hBAD0_BAD0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_if.mem_rvalid = 1'b0;
            if (done_o || busy_o) dones++;
        end
        n_checks++;
        if (dones != 0) $display("FAIL rst_stale_rvalid: got %0d active cycles want 0", dones);
        else n_pass++;
    endtask

    initial begin
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = 32'h0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half();
        test_store_byte_delayed();
        test_timeout();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
